// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic
//   Elastic valid/ready pipeline register built from STAGES cascaded stages,
//   each with a main register M and a skid register S (2 entries per stage).
//   Full throughput with no combinational ready path: each stage's ready is
//   derived only from its own registered state.
//
//   Per-stage state:
//     state | meaning
//     EMPTY | no entries held
//     ONE   | M holds a beat
//     TWO   | M and S hold beats (M is older); stage not ready
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over flush)
//   flush     synchronous discard of all held beats
//   in_valid  upstream beat present
//   in_ready  stage 0 can accept a beat (forced low while rst=1)
//   in_data   upstream payload
//   out_valid last stage holds a beat
//   out_ready downstream accepts a beat
//   out_data  last-stage payload (M of last stage)
//   count     beats currently held across all stages
module pipe_reg_elastic #(
  parameter int               WIDTH   = 32,
  parameter int               STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("pipe_reg_elastic: STAGES must be in 1..8");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  stage_state_e     st_q    [STAGES];
  stage_state_e     st_d    [STAGES];
  logic [WIDTH-1:0] m_q     [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic [WIDTH-1:0] up_data [STAGES];

  logic [STAGES-1:0] m_vld, s_vld, up_vld, dn_rdy;
  logic [STAGES-1:0] acc, emit, ld_m_in, ld_m_s, ld_s;
  logic [CW-1:0]     cnt_q;
  logic              in_xfer, out_xfer;

  always_comb begin
    m_vld = '0;
    s_vld = '0;
    for (int k = 0; k < STAGES; k++) begin
      m_vld[k] = (st_q[k] != EMPTY);
      s_vld[k] = (st_q[k] == TWO);
    end
  end

  // Stage chaining: stage k's upstream is stage k-1's M; stage k's
  // downstream ready is the registered ~S_valid of stage k+1.
  always_comb begin
    up_vld     = '0;
    dn_rdy     = '0;
    up_vld[0]  = in_valid;
    up_data[0] = in_data;
    dn_rdy[STAGES-1] = out_ready;
    for (int k = 1; k < STAGES; k++) begin
      up_vld[k]    = m_vld[k-1];
      up_data[k]   = m_q[k-1];
      dn_rdy[k-1]  = ~s_vld[k];
    end
  end

  always_comb begin
    acc     = '0;
    emit    = '0;
    ld_m_in = '0;
    ld_m_s  = '0;
    ld_s    = '0;
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = st_q[k];
      acc[k]  = up_vld[k] & ~s_vld[k];
      emit[k] = m_vld[k] & dn_rdy[k];
      case (st_q[k])
        EMPTY: begin
          if (acc[k]) begin
            st_d[k]    = ONE;
            ld_m_in[k] = 1'b1;
          end
        end
        ONE: begin
          if (acc[k] && emit[k]) begin
            ld_m_in[k] = 1'b1;
          end else if (acc[k]) begin
            st_d[k] = TWO;
            ld_s[k] = 1'b1;
          end else if (emit[k]) begin
            st_d[k] = EMPTY;
          end
        end
        TWO: begin
          if (emit[k]) begin
            st_d[k]   = ONE;
            ld_m_s[k] = 1'b1;
          end
        end
        default: st_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst || flush) st_q[k] <= EMPTY;
      else              st_q[k] <= st_d[k];
    end
  end

  // Data registers only load on an accepted beat, so X on an idle in_data
  // never reaches them. Flush leaves the data untouched.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        m_q[k] <= RST_VAL;
        s_q[k] <= RST_VAL;
      end else if (!flush) begin
        if (ld_m_in[k])     m_q[k] <= up_data[k];
        else if (ld_m_s[k]) m_q[k] <= s_q[k];
        if (ld_s[k])        s_q[k] <= up_data[k];
      end
    end
  end

  assign in_ready  = ~s_vld[0] & ~rst;
  assign out_valid = m_vld[STAGES-1];
  assign out_data  = m_q[STAGES-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush)              cnt_q <= '0;
    else if (in_xfer && !out_xfer) cnt_q <= cnt_q + CNT_ONE;
    else if (out_xfer && !in_xfer) cnt_q <= cnt_q - CNT_ONE;
  end

  assign count = cnt_q;

endmodule
